// File: rtl/riscv_single_cycle_soc.sv
`timescale 1ns/1ps
// Single-cycle RV32I-subset core with a word-organised instruction ROM and data RAM.
// One instruction retires per rising edge; the data-memory bus is exported for observation.

module soc_dmem #(
  parameter int WORDS = 64
) (
  input  logic        clk,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  output logic [31:0] rd
);
  localparam int AW = $clog2(WORDS);

  logic [31:0]   RAM [WORDS];
  logic [AW-1:0] idx;
  logic          unused_addr_bits;

  // Word addressing: byte offset ignored, high bits wrap.
  assign idx              = addr[AW+1:2];
  assign unused_addr_bits = ^{addr[31:AW+2], addr[1:0]};
  assign rd               = RAM[idx];

  always_ff @(posedge clk) begin
    if (we) RAM[idx] <= wd;
  end
endmodule

module riscv_single_cycle_soc #(
  parameter string IMEM_FILE  = "memfile_inst.hex",
  parameter string DMEM_FILE  = "memfile_data.hex",
  parameter int    IMEM_WORDS = 64,
  parameter int    DMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] data_to_mem,
  output logic [31:0] address_to_mem,
  output logic        write_enable
);
  localparam int IAW = $clog2(IMEM_WORDS);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLT = 4'd5;
  localparam logic [3:0] ALU_SLL = 4'd6;
  localparam logic [3:0] ALU_SRL = 4'd7;
  localparam logic [3:0] ALU_SRA = 4'd8;

  localparam logic [2:0] WB_ALU   = 3'd0;
  localparam logic [2:0] WB_MEM   = 3'd1;
  localparam logic [2:0] WB_PC4   = 3'd2;
  localparam logic [2:0] WB_LUI   = 3'd3;
  localparam logic [2:0] WB_AUIPC = 3'd4;

  logic [31:0] imem [IMEM_WORDS];
  logic [31:0] rf [32];
  logic [31:0] pc, next_pc, pc_plus4, instr;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3, wb_sel;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] rs1_v, rs2_v, imm_i, imm_s, imm_b, imm_j, imm_u;
  logic [31:0] op_b, alu_y, wb_data, read_data, jalr_target;
  logic [3:0]  alu_op;
  logic        reg_we, mem_we, rs_eq, rs_lt;
  logic        unused_pc_bits;

  assign instr          = imem[pc[IAW+1:2]];
  assign unused_pc_bits = ^{pc[31:IAW+2], pc[1:0]};
  assign pc_plus4       = pc + 32'd4;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};

  // rf[0] is cleared by reset and never written, so x0 always reads zero.
  assign rs1_v       = rf[rs1];
  assign rs2_v       = rf[rs2];
  assign rs_eq       = (rs1_v == rs2_v);
  assign rs_lt       = ($signed(rs1_v) < $signed(rs2_v));
  assign jalr_target = (rs1_v + imm_i) & ~32'd1;

  always_comb begin
    alu_op  = ALU_ADD;
    op_b    = imm_i;
    reg_we  = 1'b0;
    mem_we  = 1'b0;
    wb_sel  = WB_ALU;
    next_pc = pc_plus4;
    case (opcode)
      OP_R: begin
        op_b   = rs2_v;
        reg_we = 1'b1;
        case ({funct7, funct3})
          10'b0000000_000: alu_op = ALU_ADD;
          10'b0100000_000: alu_op = ALU_SUB;
          10'b0000000_001: alu_op = ALU_SLL;
          10'b0000000_010: alu_op = ALU_SLT;
          10'b0000000_100: alu_op = ALU_XOR;
          10'b0000000_101: alu_op = ALU_SRL;
          10'b0100000_101: alu_op = ALU_SRA;
          10'b0000000_110: alu_op = ALU_OR;
          10'b0000000_111: alu_op = ALU_AND;
          default:         reg_we = 1'b0;
        endcase
      end
      OP_I: begin
        reg_we = 1'b1;
        case (funct3)
          3'b000:  alu_op = ALU_ADD;
          3'b010:  alu_op = ALU_SLT;
          3'b110:  alu_op = ALU_OR;
          3'b111:  alu_op = ALU_AND;
          default: reg_we = 1'b0;
        endcase
      end
      OP_LW: begin
        reg_we = (funct3 == 3'b010);
        wb_sel = WB_MEM;
      end
      OP_SW: begin
        op_b   = imm_s;
        mem_we = (funct3 == 3'b010);
      end
      OP_BR: begin
        op_b   = rs2_v;
        alu_op = ALU_SUB;
        if ((funct3 == 3'b000 && rs_eq) || (funct3 == 3'b001 && !rs_eq) ||
            (funct3 == 3'b100 && rs_lt))
          next_pc = pc + imm_b;
      end
      OP_LUI: begin
        reg_we = 1'b1;
        wb_sel = WB_LUI;
      end
      OP_AUIPC: begin
        reg_we = 1'b1;
        wb_sel = WB_AUIPC;
      end
      OP_JAL: begin
        reg_we  = 1'b1;
        wb_sel  = WB_PC4;
        next_pc = pc + imm_j;
      end
      OP_JALR: begin
        if (funct3 == 3'b000) begin
          reg_we  = 1'b1;
          wb_sel  = WB_PC4;
          next_pc = jalr_target;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    alu_y = rs1_v + op_b;
    case (alu_op)
      ALU_SUB: alu_y = rs1_v - op_b;
      ALU_AND: alu_y = rs1_v & op_b;
      ALU_OR:  alu_y = rs1_v | op_b;
      ALU_XOR: alu_y = rs1_v ^ op_b;
      ALU_SLT: alu_y = {31'b0, $signed(rs1_v) < $signed(op_b)};
      ALU_SLL: alu_y = rs1_v << op_b[4:0];
      ALU_SRL: alu_y = rs1_v >> op_b[4:0];
      ALU_SRA: alu_y = $signed(rs1_v) >>> op_b[4:0];
      default: alu_y = rs1_v + op_b;
    endcase
  end

  always_comb begin
    wb_data = alu_y;
    case (wb_sel)
      WB_MEM:   wb_data = read_data;
      WB_PC4:   wb_data = pc_plus4;
      WB_LUI:   wb_data = imm_u;
      WB_AUIPC: wb_data = pc + imm_u;
      default:  wb_data = alu_y;
    endcase
  end

  assign address_to_mem = alu_y;
  assign data_to_mem    = rs2_v;
  assign write_enable   = mem_we & ~reset;

  soc_dmem #(.WORDS(DMEM_WORDS)) dmem (
    .clk  (clk),
    .we   (write_enable),
    .addr (address_to_mem),
    .wd   (data_to_mem),
    .rd   (read_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc <= '0;
    else       pc <= next_pc;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (reg_we && rd != 5'd0) begin
      rf[rd] <= wb_data;
    end
  end
endmodule

// File: tb/tb_riscv_single_cycle_soc.sv
`timescale 1ns/100ps
// Bench for riscv_single_cycle_soc: directed programs, an ALU vector table, and random
// straight-line programs checked against an instruction-level reference model.
module tb_riscv_single_cycle_soc;
  localparam int IMEM_WORDS = 64;
  localparam int DMEM_WORDS = 64;
  localparam logic [31:0] J_SELF = 32'h0000006F;
  localparam logic [6:0] OPC_I  = 7'b0010011;
  localparam logic [6:0] OPC_LW = 7'b0000011;

  // Clock / reset
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] data_to_mem, address_to_mem;
  logic        write_enable;

  always #1 clk = ~clk;

  riscv_single_cycle_soc #(.IMEM_WORDS(IMEM_WORDS), .DMEM_WORDS(DMEM_WORDS)) dut (
    .clk            (clk),
    .reset          (reset),
    .data_to_mem    (data_to_mem),
    .address_to_mem (address_to_mem),
    .write_enable   (write_enable)
  );

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] prog[$];
  logic [31:0] exp_q[$];

  typedef struct {
    string       name;
    logic [6:0]  f7;
    logic [2:0]  f3;
    int          a;
    int          b;
    logic [31:0] exp;
  } alu_vec_t;
  alu_vec_t vecs[12];

  // Assembler helpers
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                        input int rd, input int rs1, input int rs2);
    return {f7, rs2[4:0], rs1[4:0], f3, rd[4:0], 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_i(input logic [2:0] f3, input int rd, input int rs1,
                                        input int imm, input logic [6:0] op);
    return {imm[11:0], rs1[4:0], f3, rd[4:0], op};
  endfunction
  function automatic logic [31:0] enc_s(input int rs2, input int rs1, input int imm);
    return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [2:0] f3, input int rs1, input int rs2,
                                        input int imm);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_u(input logic [6:0] op, input int rd, input logic [19:0] u);
    return {u, rd[4:0], op};
  endfunction
  function automatic logic [31:0] enc_j(input int rd, input int imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
  endfunction
  function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
    return enc_i(3'b000, rd, rs1, imm, OPC_I);
  endfunction

  // Driver tasks
  task automatic load_prog();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < IMEM_WORDS; i++)
      dut.imem[i] <= (i < prog.size()) ? prog[i] : J_SELF;
  endtask

  task automatic poke(input int w, input logic [31:0] v);
    dut.dmem.RAM[w] <= v;
  endtask

  task automatic release_rst();
    @(negedge clk);
    reset = 1'b0;
    #0.5;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
    #0.5;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Random straight-line program, scored against an instruction-level model
  task automatic random_round(input int round);
    logic [31:0] r [32];
    logic [31:0] m [DMEM_WORDS];
    logic [31:0] a, b, res, pcv, ins;
    logic [19:0] u;
    int          kind, rd, rs1, rs2, imm, w;
    bit          wr;
    prog.delete();
    for (int i = 0; i < 32; i++) r[i] = '0;
    for (int i = 0; i < DMEM_WORDS; i++) m[i] = $urandom();
    for (int i = 0; i < 20; i++) begin
      kind = $urandom_range(0, 16);
      rd   = $urandom_range(0, 8);
      rs1  = $urandom_range(0, 8);
      rs2  = $urandom_range(0, 8);
      imm  = int'($urandom_range(0, 4095)) - 2048;
      w    = $urandom_range(32, 47);
      u    = 20'($urandom());
      a    = r[rs1];
      b    = r[rs2];
      pcv  = 32'(i * 4);
      wr   = 1'b1;
      res  = '0;
      case (kind)
        0:  begin ins = enc_r(7'h00, 3'b000, rd, rs1, rs2); res = a + b; end
        1:  begin ins = enc_r(7'h20, 3'b000, rd, rs1, rs2); res = a - b; end
        2:  begin ins = enc_r(7'h00, 3'b001, rd, rs1, rs2); res = a << b[4:0]; end
        3:  begin ins = enc_r(7'h00, 3'b010, rd, rs1, rs2); res = ($signed(a) < $signed(b)) ? 1 : 0; end
        4:  begin ins = enc_r(7'h00, 3'b100, rd, rs1, rs2); res = a ^ b; end
        5:  begin ins = enc_r(7'h00, 3'b101, rd, rs1, rs2); res = a >> b[4:0]; end
        6:  begin ins = enc_r(7'h20, 3'b101, rd, rs1, rs2); res = $signed(a) >>> b[4:0]; end
        7:  begin ins = enc_r(7'h00, 3'b110, rd, rs1, rs2); res = a | b; end
        8:  begin ins = enc_r(7'h00, 3'b111, rd, rs1, rs2); res = a & b; end
        9:  begin ins = addi(rd, rs1, imm); res = a + 32'(imm); end
        10: begin ins = enc_i(3'b010, rd, rs1, imm, OPC_I); res = ($signed(a) < imm) ? 1 : 0; end
        11: begin ins = enc_i(3'b110, rd, rs1, imm, OPC_I); res = a | 32'(imm); end
        12: begin ins = enc_i(3'b111, rd, rs1, imm, OPC_I); res = a & 32'(imm); end
        13: begin ins = enc_i(3'b010, rd, 0, w * 4, OPC_LW); res = m[w]; end
        14: begin ins = enc_s(rs2, 0, w * 4); m[w] = b; wr = 1'b0; end
        15: begin ins = enc_u(7'b0110111, rd, u); res = {u, 12'b0}; end
        default: begin ins = enc_u(7'b0010111, rd, u); res = pcv + {u, 12'b0}; end
      endcase
      prog.push_back(ins);
      if (wr && rd != 0) r[rd] = res;
    end
    for (int k = 1; k <= 8; k++) begin
      prog.push_back(enc_s(k, 0, (7 + k) * 4));
      exp_q.push_back(r[k]);
    end
    for (int k = 32; k < 48; k++) exp_q.push_back(m[k]);
    load_prog();
    for (int k = 0; k < DMEM_WORDS; k++) poke(k, m[k]);
    release_rst();
    run(29);
    for (int k = 1; k <= 8; k++)
      check($sformatf("rand%0d_x%0d", round, k), dut.dmem.RAM[7 + k], exp_q.pop_front());
    for (int k = 32; k < 48; k++)
      check($sformatf("rand%0d_ram%0d", round, k), dut.dmem.RAM[k], exp_q.pop_front());
  endtask

  initial begin : main
    int early;
    vecs[0]  = '{"add",     7'h00, 3'b000,     5,    7, 32'd12};
    vecs[1]  = '{"sub_neg", 7'h20, 3'b000,     5,    7, 32'hFFFF_FFFE};
    vecs[2]  = '{"and",     7'h00, 3'b111,   240,  255, 32'h0000_00F0};
    vecs[3]  = '{"or",      7'h00, 3'b110,   240,   15, 32'h0000_00FF};
    vecs[4]  = '{"xor",     7'h00, 3'b100,  2047,   -1, 32'hFFFF_F800};
    vecs[5]  = '{"slt_t",   7'h00, 3'b010,    -3,    2, 32'd1};
    vecs[6]  = '{"slt_f",   7'h00, 3'b010,     2,   -3, 32'd0};
    vecs[7]  = '{"sll_31",  7'h00, 3'b001,     1,   31, 32'h8000_0000};
    vecs[8]  = '{"sll_wrap",7'h00, 3'b001,     3,   33, 32'd6};
    vecs[9]  = '{"srl",     7'h00, 3'b101,   -16,   28, 32'h0000_000F};
    vecs[10] = '{"sra",     7'h20, 3'b101,   -16,    2, 32'hFFFF_FFFC};
    vecs[11] = '{"sra_wrap",7'h20, 3'b101, -2048,   33, 32'hFFFF_FC00};

    // Reset: a store at address 0 must stay suppressed while reset is high
    prog = {enc_s(0, 0, 8)};
    load_prog();
    poke(2, 32'hDEAD_BEEF);
    #0.5;
    check("reset_pc", dut.pc, 32'd0);
    check("reset_we", {31'b0, write_enable}, 32'd0);
    release_rst();
    check("reset_ram_untouched", dut.dmem.RAM[2], 32'hDEAD_BEEF);
    check("first_instr_we", {31'b0, write_enable}, 32'd1);
    check("first_instr_addr", address_to_mem, 32'd8);
    run(1);
    check("first_instr_store", dut.dmem.RAM[2], 32'd0);

    // ALU vector table
    for (int i = 0; i < 12; i++) begin
      prog = {addi(1, 0, vecs[i].a), addi(2, 0, vecs[i].b),
              enc_r(vecs[i].f7, vecs[i].f3, 3, 1, 2), enc_s(3, 0, 0)};
      load_prog();
      release_rst();
      run(4);
      check({"alu_", vecs[i].name}, dut.dmem.RAM[0], vecs[i].exp);
    end

    // ADDI/ADD/SW bus and commit
    prog = {addi(1, 0, 5), addi(2, 0, 7), enc_r(7'h00, 3'b000, 3, 1, 2), enc_s(3, 0, 8)};
    load_prog();
    release_rst();
    run(3);
    check("sw_addr", address_to_mem, 32'd8);
    check("sw_data", data_to_mem, 32'd12);
    check("sw_we", {31'b0, write_enable}, 32'd1);
    run(1);
    check("sw_ram2", dut.dmem.RAM[2], 32'd12);

    // LW/SUB
    prog = {enc_i(3'b010, 4, 0, 4, OPC_LW), addi(5, 0, 30), enc_r(7'h20, 3'b000, 6, 4, 5),
            enc_s(6, 0, 0)};
    load_prog();
    poke(1, 32'd100);
    release_rst();
    check("lw_addr", address_to_mem, 32'd4);
    check("lw_we", {31'b0, write_enable}, 32'd0);
    run(4);
    check("lw_sub_ram0", dut.dmem.RAM[0], 32'd70);

    // Branch loop, with a reset dropped in mid-loop
    prog = {addi(1, 0, 0), addi(2, 0, 5), addi(1, 1, 1), enc_b(3'b100, 1, 2, -4), enc_s(1, 0, 12)};
    load_prog();
    release_rst();
    run(5);
    @(negedge clk);
    reset = 1'b1;
    #0.5;
    check("mid_reset_pc", dut.pc, 32'd0);
    check("mid_reset_dmem_kept", dut.dmem.RAM[0], 32'd70);
    release_rst();
    early = 0;
    for (int c = 0; c < 12; c++) begin
      if (write_enable) early++;
      run(1);
    end
    check("loop_no_early_store", 32'(early), 32'd0);
    check("loop_exit_we", {31'b0, write_enable}, 32'd1);
    check("loop_exit_addr", address_to_mem, 32'd12);
    check("loop_exit_data", data_to_mem, 32'd5);
    run(1);
    check("loop_ram3", dut.dmem.RAM[3], 32'd5);

    // JAL/JALR/LUI
    prog = {enc_j(1, 8), addi(10, 0, 1), enc_u(7'b0110111, 7, 20'h12345), enc_s(7, 0, 16),
            enc_s(1, 0, 20), enc_i(3'b000, 11, 1, 25, 7'b1100111), enc_s(7, 0, 24),
            enc_s(11, 0, 28), enc_s(10, 0, 32)};
    load_prog();
    poke(6, 32'hDEAD_0006);
    poke(8, 32'h0000_0055);
    release_rst();
    run(7);
    check("lui_ram4", dut.dmem.RAM[4], 32'h1234_5000);
    check("jal_link", dut.dmem.RAM[5], 32'd4);
    check("jalr_skip", dut.dmem.RAM[6], 32'hDEAD_0006);
    check("jalr_link", dut.dmem.RAM[7], 32'd24);
    check("jal_skip", dut.dmem.RAM[8], 32'd0);

    // x0 immutability and SRA by register
    prog = {addi(0, 0, 9), addi(8, 0, -16), addi(12, 0, 2), enc_r(7'h20, 3'b101, 9, 8, 12),
            enc_s(9, 0, 0), enc_s(0, 0, 4)};
    load_prog();
    poke(1, 32'h0000_1111);
    release_rst();
    run(6);
    check("sra_x9", dut.dmem.RAM[0], 32'hFFFF_FFFC);
    check("x0_zero", dut.dmem.RAM[1], 32'd0);

    // BEQ taken, BNE not taken, unsupported encodings, AUIPC
    prog = {addi(1, 0, 3), addi(2, 0, 3), enc_b(3'b000, 1, 2, 8), enc_s(1, 0, 0),
            enc_b(3'b001, 1, 2, 8), 32'h0000_810B, enc_i(3'b100, 2, 0, 127, OPC_I),
            enc_s(2, 0, 36), enc_u(7'b0010111, 4, 20'h00001), enc_s(4, 0, 40)};
    load_prog();
    poke(0, 32'hAAAA_5555);
    release_rst();
    run(9);
    check("beq_skip", dut.dmem.RAM[0], 32'hAAAA_5555);
    check("unsupported_no_write", dut.dmem.RAM[9], 32'd3);
    check("auipc", dut.dmem.RAM[10], 32'h0000_1020);

    for (int rnd = 0; rnd < 6; rnd++) random_round(rnd);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
